// File: rtl/acc_csr_pkg.sv
// Shared definitions for the ICB CSR bank: widths, control/status bit positions
// and the offsets of the registers that follow the config block.
package acc_csr_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_ABORT_BIT  = 1;
  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned STATUS_BUSY_BIT = 1;
  localparam int unsigned IRQ_EN_BIT      = 0;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_IRQ_EN = 2'd2
  } ctl_reg_e;

  typedef struct packed {
    logic [REG_W-1:0] rdata;
    logic             err;
  } rsp_t;

  // CTRL, STATUS and IRQ_EN sit in consecutive words right after the last CFG word.
  function automatic logic [ADDR_W-1:0] ctl_offset(input int unsigned num_cfg, input ctl_reg_e sel);
    return 32'(4 * num_cfg) + {28'd0, sel, 2'b00};
  endfunction

endpackage

// File: rtl/icb_csr_bank_if.sv
// ICB command/response channel between the CPU bus master and the CSR bank.
interface icb_csr_bank_if;
  import acc_csr_pkg::*;

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic              icb_cmd_read;
  logic [ADDR_W-1:0] icb_cmd_addr;
  logic [REG_W-1:0]  icb_cmd_wdata;
  logic [MASK_W-1:0] icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic [REG_W-1:0]  icb_rsp_rdata;
  logic              icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_rsp_slot.sv
// One-entry response register: holds a single outstanding ICB response and
// only lets a new command in when the slot is empty or draining this cycle.
module icb_rsp_slot
  import acc_csr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  rsp_t rsp_i,
  input  logic rsp_ready_i,
  output logic valid_o,
  output rsp_t rsp_o,
  output logic ready_o
);

  logic valid_q, valid_d;
  rsp_t rsp_q, rsp_d;

  // Load wins over drain so back-to-back commands keep the slot full.
  always_comb begin
    valid_d = valid_q;
    rsp_d   = rsp_q;
    if (load_i) begin
      valid_d = 1'b1;
      rsp_d   = rsp_i;
    end else if (rsp_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rsp_q   <= '{rdata: 32'h0, err: 1'b0};
    end else begin
      valid_q <= valid_d;
      rsp_q   <= rsp_d;
    end
  end

  assign valid_o = valid_q;
  assign rsp_o   = rsp_q;
  assign ready_o = rst_n & (~valid_q | rsp_ready_i);

endmodule

// File: rtl/icb_csr_bank.sv
// Parametrised ICB register bank: NUM_CFG byte-maskable config words plus
// CTRL (start/abort pulses), STATUS (sticky done, live busy) and IRQ_EN.
module icb_csr_bank
  import acc_csr_pkg::*;
#(
  parameter logic [ADDR_W-1:0]        BASE_ADDR = 32'h0000_0000,
  parameter int unsigned              NUM_CFG   = 8,
  parameter logic [NUM_CFG*REG_W-1:0] CFG_RST   = {NUM_CFG{32'h0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  icb_csr_bank_if.slave            icb,
  output logic [NUM_CFG*REG_W-1:0] cfg_o,
  output logic                     start_o,
  output logic                     abort_o,
  input  logic                     busy_i,
  input  logic                     done_i,
  output logic                     irq_o
);

  localparam logic [ADDR_W-1:0] CTRL_OFF   = ctl_offset(NUM_CFG, REG_CTRL);
  localparam logic [ADDR_W-1:0] STATUS_OFF = ctl_offset(NUM_CFG, REG_STATUS);
  localparam logic [ADDR_W-1:0] IRQ_EN_OFF = ctl_offset(NUM_CFG, REG_IRQ_EN);

  logic [NUM_CFG-1:0][REG_W-1:0] cfg_q, cfg_d;
  logic done_q, done_d;
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
  logic start_q, start_d;
  logic abort_q, abort_d;

  logic [ADDR_W-1:0]  offset;
  logic [NUM_CFG-1:0] hit_cfg;
  logic               hit_ctrl, hit_status, hit_irq_en, hit_any;
  logic               dec_err, cmd_fire, wr_ok, ctrl_wr, done_clr;
  logic [REG_W-1:0]   status_word, rd_data;
  logic               slot_ready, slot_valid;
  rsp_t               slot_rsp;

  assign cmd_fire = icb.icb_cmd_valid & slot_ready;

  // Address decode, error classification and read mux for the presented command.
  always_comb begin
    offset     = icb.icb_cmd_addr - BASE_ADDR;
    hit_cfg    = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      hit_cfg[i] = (offset == 32'(4 * i));
    end
    hit_ctrl   = (offset == CTRL_OFF);
    hit_status = (offset == STATUS_OFF);
    hit_irq_en = (offset == IRQ_EN_OFF);
    hit_any    = (|hit_cfg) | hit_ctrl | hit_status | hit_irq_en;
    // CFG is frozen while the accelerator runs; such writes are rejected outright.
    dec_err    = (icb.icb_cmd_addr[1:0] != 2'b00) | ~hit_any
               | (~icb.icb_cmd_read & busy_i & (|hit_cfg));
    wr_ok      = cmd_fire & ~icb.icb_cmd_read & ~dec_err;

    status_word                  = '0;
    status_word[STATUS_DONE_BIT] = done_q;
    status_word[STATUS_BUSY_BIT] = busy_i;

    rd_data = ({REG_W{hit_status}} & status_word)
            | ({REG_W{hit_irq_en}} & {31'd0, irq_en_q});
    for (int i = 0; i < NUM_CFG; i++) begin
      rd_data = rd_data | ({REG_W{hit_cfg[i]}} & cfg_q[i]);
    end
    rd_data = rd_data & {REG_W{icb.icb_cmd_read & ~dec_err}};
  end

  // Next-state for config words, control pulses, done/irq bookkeeping.
  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_CFG; i++) begin
      for (int k = 0; k < MASK_W; k++) begin
        cfg_d[i][8*k +: 8] = (wr_ok & hit_cfg[i] & icb.icb_cmd_wmask[k])
                           ? icb.icb_cmd_wdata[8*k +: 8] : cfg_q[i][8*k +: 8];
      end
    end
    ctrl_wr  = wr_ok & hit_ctrl & icb.icb_cmd_wmask[0];
    abort_d  = ctrl_wr & icb.icb_cmd_wdata[CTRL_ABORT_BIT];
    start_d  = ctrl_wr & icb.icb_cmd_wdata[CTRL_START_BIT]
             & ~icb.icb_cmd_wdata[CTRL_ABORT_BIT] & ~busy_i;
    done_clr = wr_ok & hit_status & icb.icb_cmd_wmask[0] & icb.icb_cmd_wdata[STATUS_DONE_BIT];
    done_d   = done_i | (done_q & ~done_clr);
    irq_en_d = (wr_ok & hit_irq_en & icb.icb_cmd_wmask[0])
             ? icb.icb_cmd_wdata[IRQ_EN_BIT] : irq_en_q;
    irq_d    = done_q & irq_en_q;
  end

  // Register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q    <= CFG_RST;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
    end
  end

  icb_rsp_slot u_rsp_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (cmd_fire),
    .rsp_i       ('{rdata: rd_data, err: dec_err}),
    .rsp_ready_i (icb.icb_rsp_ready),
    .valid_o     (slot_valid),
    .rsp_o       (slot_rsp),
    .ready_o     (slot_ready)
  );

  assign icb.icb_cmd_ready = slot_ready;
  assign icb.icb_rsp_valid = slot_valid;
  assign icb.icb_rsp_rdata = slot_rsp.rdata;
  assign icb.icb_rsp_err   = slot_rsp.err;
  assign cfg_o             = cfg_q;
  assign start_o           = start_q;
  assign abort_o           = abort_q;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_icb_csr_bank.sv
// Self-checking bench for icb_csr_bank: directed vector table, hand sequences
// for handshake/pulse/irq/reset corners, then random traffic against a model.
module tb_icb_csr_bank;

  localparam int          NUM_CFG = 8;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [NUM_CFG*32-1:0] CFG_RST = {
    32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
    32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  localparam logic [31:0] CTRL_A   = BASE + 32'h20;
  localparam logic [31:0] STATUS_A = BASE + 32'h24;
  localparam logic [31:0] IRQEN_A  = BASE + 32'h28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, busy_i, done_i, start_o, abort_o, irq_o;
  logic [NUM_CFG*32-1:0] cfg_o;

  icb_csr_bank_if icb();

  icb_csr_bank #(.BASE_ADDR(BASE), .NUM_CFG(NUM_CFG), .CFG_RST(CFG_RST)) dut (
    .clk(clk), .rst_n(rst_n), .icb(icb), .cfg_o(cfg_o), .start_o(start_o),
    .abort_o(abort_o), .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o));

  // Reference model state, described at register-map level.
  logic [31:0] m_cfg [NUM_CFG];
  bit          m_done, m_irq_en, m_irq, m_start, m_abort, m_rsp_valid, m_err;
  logic [31:0] m_rdata;
  bit          seen_ready;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wm;
    bit          busy;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wm, input bit busy, input logic [31:0] er, input bit ee);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.wm = wm; v.busy = busy;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = CFG_RST[32*i +: 32];
    m_done = 0; m_irq_en = 0; m_irq = 0; m_start = 0; m_abort = 0;
    m_rsp_valid = 0; m_err = 0; m_rdata = 32'h0;
  endtask

  task automatic set_cmd(input bit v, input bit rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
    icb.icb_cmd_valid = v; icb.icb_cmd_read = rd; icb.icb_cmd_addr = a;
    icb.icb_cmd_wdata = wd; icb.icb_cmd_wmask = wm;
  endtask

  // One clock: check cmd_ready, advance the model, then compare all outputs.
  task automatic do_cycle();
    bit exp_ready, fire, clr, nx_start, nx_abort, nx_irq, er, was_rst;
    logic [31:0] off, rd;
    int idx;
    #1;
    exp_ready  = rst_n && (!m_rsp_valid || icb.icb_rsp_ready);
    seen_ready = icb.icb_cmd_ready;
    check1("cmd_ready", icb.icb_cmd_ready, exp_ready);
    fire = icb.icb_cmd_valid && exp_ready;
    was_rst = !rst_n;
    if (!rst_n) begin
      model_reset();
    end else begin
      clr = 0; nx_start = 0; nx_abort = 0;
      nx_irq = m_done && m_irq_en;
      if (fire) begin
        off = icb.icb_cmd_addr - BASE; rd = 32'h0; er = 0;
        if (icb.icb_cmd_addr[1:0] != 2'd0) er = 1;
        else if (off < 32'(4 * NUM_CFG)) begin
          idx = int'(off >> 2);
          if (icb.icb_cmd_read) rd = m_cfg[idx];
          else if (busy_i) er = 1;
          else for (int k = 0; k < 4; k++)
            if (icb.icb_cmd_wmask[k]) m_cfg[idx][8*k +: 8] = icb.icb_cmd_wdata[8*k +: 8];
        end else if (off == 32'(4 * NUM_CFG)) begin
          if (!icb.icb_cmd_read && icb.icb_cmd_wmask[0]) begin
            nx_abort = icb.icb_cmd_wdata[1];
            nx_start = icb.icb_cmd_wdata[0] && !icb.icb_cmd_wdata[1] && !busy_i;
          end
        end else if (off == 32'(4 * NUM_CFG + 4)) begin
          if (icb.icb_cmd_read) rd = {30'd0, busy_i, m_done};
          else if (icb.icb_cmd_wmask[0] && icb.icb_cmd_wdata[0]) clr = 1;
        end else if (off == 32'(4 * NUM_CFG + 8)) begin
          if (icb.icb_cmd_read) rd = {31'd0, m_irq_en};
          else if (icb.icb_cmd_wmask[0]) m_irq_en = icb.icb_cmd_wdata[0];
        end else er = 1;
        m_rsp_valid = 1; m_rdata = rd; m_err = er;
      end else if (m_rsp_valid && icb.icb_rsp_ready) begin
        m_rsp_valid = 0;
      end
      m_done  = done_i ? 1'b1 : (clr ? 1'b0 : m_done);
      m_irq   = nx_irq;
      m_start = nx_start;
      m_abort = nx_abort;
    end
    @(posedge clk);
    #1;
    check1("rsp_valid", icb.icb_rsp_valid, m_rsp_valid);
    if (m_rsp_valid || was_rst) begin
      check("rsp_rdata", icb.icb_rsp_rdata, m_rdata);
      check1("rsp_err", icb.icb_rsp_err, m_err);
    end
    check1("start_o", start_o, m_start);
    check1("abort_o", abort_o, m_abort);
    check1("irq_o", irq_o, m_irq);
    for (int i = 0; i < NUM_CFG; i++) check("cfg_o", cfg_o[32*i +: 32], m_cfg[i]);
  endtask

  logic [31:0] hold;
  int          n_acc;
  logic [31:0] bp_exp [4];

  initial begin
    rst_n = 0; busy_i = 0; done_i = 0; icb.icb_rsp_ready = 1;
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0);
    model_reset();
    do_cycle(); do_cycle();
    check1("rst_rsp_valid", icb.icb_rsp_valid, 1'b0);
    check("rst_rdata", icb.icb_rsp_rdata, 32'h0);
    check1("rst_start", start_o, 1'b0);
    check1("rst_irq", irq_o, 1'b0);
    check("rst_cfg5", cfg_o[191:160], 32'hC0DE_0005);
    rst_n = 1;

    vt[0]  = mk(1, BASE + 32'h00, 32'h0, 4'h0, 0, 32'hC0DE_0000, 0);
    vt[1]  = mk(1, BASE + 32'h1C, 32'h0, 4'h0, 0, 32'hC0DE_0007, 0);
    vt[2]  = mk(0, BASE + 32'h08, 32'h1122_3344, 4'hF, 0, 32'h0, 0);
    vt[3]  = mk(0, BASE + 32'h08, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 0);
    vt[4]  = mk(1, BASE + 32'h08, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);
    vt[5]  = mk(0, BASE + 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 0);
    vt[6]  = mk(1, BASE + 32'h0C, 32'h0, 4'h0, 0, 32'hC0DE_0003, 0);
    vt[7]  = mk(1, BASE + 32'h2C, 32'h0, 4'h0, 0, 32'h0, 1);
    vt[8]  = mk(1, BASE + 32'h05, 32'h0, 4'h0, 0, 32'h0, 1);
    vt[9]  = mk(0, BASE + 32'h2C, 32'h1234_5678, 4'hF, 0, 32'h0, 1);
    vt[10] = mk(1, BASE + 32'h08, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);
    vt[11] = mk(1, CTRL_A, 32'h0, 4'h0, 0, 32'h0, 0);
    vt[12] = mk(0, IRQEN_A, 32'h1, 4'h1, 0, 32'h0, 0);
    vt[13] = mk(1, IRQEN_A, 32'h0, 4'h0, 0, 32'h1, 0);
    vt[14] = mk(0, IRQEN_A, 32'hFFFF_FFFE, 4'b1110, 0, 32'h0, 0);
    vt[15] = mk(1, IRQEN_A, 32'h0, 4'h0, 0, 32'h1, 0);
    vt[16] = mk(1, STATUS_A, 32'h0, 4'h0, 1, 32'h2, 0);
    vt[17] = mk(0, BASE + 32'h04, 32'h5555_5555, 4'hF, 1, 32'h0, 1);
    vt[18] = mk(1, BASE + 32'h04, 32'h0, 4'h0, 0, 32'hC0DE_0001, 0);
    vt[19] = mk(1, 32'h3FFF_FFFC, 32'h0, 4'h0, 0, 32'h0, 1);
    vt[20] = mk(0, IRQEN_A, 32'h0, 4'h1, 0, 32'h0, 0);
    for (int i = 0; i < 21; i++) begin
      set_cmd(1, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wm);
      busy_i = vt[i].busy;
      do_cycle();
      check("tbl_rdata", icb.icb_rsp_rdata, vt[i].exp_rdata);
      check1("tbl_err", icb.icb_rsp_err, vt[i].exp_err);
    end
    busy_i = 0; set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();

    // Backpressure: one stalled response, then four commands back to back.
    icb.icb_rsp_ready = 0;
    set_cmd(1, 1, BASE + 32'h08, 32'h0, 4'h0); do_cycle();
    hold = icb.icb_rsp_rdata;
    set_cmd(1, 1, BASE + 32'h00, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      do_cycle();
      check1("bp_cmd_ready", seen_ready, 1'b0);
      check1("bp_valid_held", icb.icb_rsp_valid, 1'b1);
      check("bp_rdata_held", icb.icb_rsp_rdata, hold);
    end
    check("bp_hold_value", hold, 32'h11BB_33DD);
    icb.icb_rsp_ready = 1; n_acc = 0;
    bp_exp[0] = 32'hC0DE_0000; bp_exp[1] = 32'hC0DE_0001;
    bp_exp[2] = 32'h11BB_33DD; bp_exp[3] = 32'hC0DE_0003;
    for (int c = 0; c < 4; c++) begin
      set_cmd(1, 1, BASE + 32'(4 * c), 32'h0, 4'h0);
      do_cycle();
      if (seen_ready) n_acc++;
      check("b2b_rdata", icb.icb_rsp_rdata, bp_exp[c]);
    end
    check("b2b_accepted", 32'(n_acc), 32'd4);
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();

    // Start/abort pulses.
    set_cmd(1, 0, CTRL_A, 32'h1, 4'h1); do_cycle();
    check1("start_pulse", start_o, 1'b1);
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();
    check1("start_one_cycle", start_o, 1'b0);
    busy_i = 1; set_cmd(1, 0, CTRL_A, 32'h1, 4'h1); do_cycle();
    check1("start_busy_supp", start_o, 1'b0);
    check1("start_busy_err", icb.icb_rsp_err, 1'b0);
    busy_i = 0; set_cmd(1, 0, CTRL_A, 32'h3, 4'h1); do_cycle();
    check1("abort_pulse", abort_o, 1'b1);
    check1("abort_wins", start_o, 1'b0);
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();
    check1("abort_one_cycle", abort_o, 1'b0);

    // done / irq, including set-beats-clear.
    set_cmd(1, 0, IRQEN_A, 32'h1, 4'h1); do_cycle();
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0); done_i = 1; do_cycle();
    done_i = 0; do_cycle();
    check1("irq_set", irq_o, 1'b1);
    set_cmd(1, 0, STATUS_A, 32'h1, 4'h1); done_i = 1; do_cycle();
    done_i = 0; set_cmd(1, 1, STATUS_A, 32'h0, 4'h0); do_cycle();
    check("done_set_wins", icb.icb_rsp_rdata, 32'h1);
    set_cmd(1, 0, STATUS_A, 32'h1, 4'h1); do_cycle();
    check1("irq_lag", irq_o, 1'b1);
    set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();
    check1("irq_clear", irq_o, 1'b0);

    // Reset with a response pending.
    icb.icb_rsp_ready = 0;
    set_cmd(1, 0, BASE, 32'hDEAD_BEEF, 4'hF); do_cycle();
    rst_n = 0; do_cycle();
    check1("rst_drop_valid", icb.icb_rsp_valid, 1'b0);
    for (int i = 0; i < NUM_CFG; i++) check("rst_cfg", cfg_o[32*i +: 32], CFG_RST[32*i +: 32]);
    rst_n = 1; icb.icb_rsp_ready = 1; set_cmd(0, 0, 32'h0, 32'h0, 4'h0); do_cycle();
    check1("rst_no_rsp", icb.icb_rsp_valid, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = BASE + 32'(4 * $urandom_range(0, NUM_CFG - 1));
      else if (kind == 6) a = CTRL_A;
      else if (kind == 7) a = STATUS_A;
      else if (kind == 8) a = IRQEN_A;
      else                a = BASE + 32'($urandom_range(0, 63));
      set_cmd($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom(), 4'($urandom_range(0, 15)));
      icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
      busy_i = ($urandom_range(0, 3) == 0);
      done_i = ($urandom_range(0, 7) == 0);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icb_csr_bank.md
Name: icb_csr_bank

Overview:
- Parametrised ICB slave register bank for the accelerator. It is the next generation of the fixed nine-register config slave.
- Provides NUM_CFG byte-maskable config registers and a CTRL register (start/abort pulses).
- Also provides a STATUS register (sticky done, write-1-to-clear; busy read-only) and an interrupt-enable register driving a level IRQ.
- Sits between the CPU ICB bus and the main conv FSM. It adds a correct single-outstanding valid/ready handshake and error responses.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of register offset 0; compared on all 32 bits.
- NUM_CFG, 8, number of 32-bit config registers (1..32).
- CFG_RST, {NUM_CFG{32'h0}}, flat NUM_CFG*32 reset values; CFG[i] is bits [32*i+31:32*i].

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_addr  in  32  byte address
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables, bit k -> wdata[8k+7:8k]
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted when valid&ready
- icb_rsp_rdata  out  32  read data (0 for writes and errors)
- icb_rsp_err  out  1  error response
- cfg_o  out  NUM_CFG*32  config register contents
- start_o  out  1  one-cycle start pulse
- abort_o  out  1  one-cycle abort pulse
- busy_i  in  1  accelerator busy level
- done_i  in  1  conv-finish pulse
- irq_o  out  1  interrupt level

Behaviour:
- Reset (rst_n=0 at posedge clk): cmd_ready=0 (combinational view; see below), rsp_valid=0, rsp_rdata=0, rsp_err=0, cfg_o=CFG_RST, start_o=0, abort_o=0, done=0, irq_en=0, irq_o=0.
- Register map, offset = addr-BASE_ADDR:
  - CFG[i] at offset 4*i.
  - CTRL at 4*NUM_CFG: bit0 start, bit1 abort; write-only pulses, reads 0.
  - STATUS at 4*NUM_CFG+4: bit0 done (W1C), bit1 busy (RO, live busy_i).
  - IRQ_EN at 4*NUM_CFG+8: bit0, RW.
- Handshake:
  - icb_cmd_ready = rst_n & (!rsp_valid | icb_rsp_ready), combinational. At most one response is outstanding.
  - A command accepted at edge N produces rsp_valid=1 with rdata/err from edge N (1-cycle latency).
  - rsp_valid clears on rsp accept unless a new command is accepted in the same cycle, giving back-to-back throughput of 1/cycle.
  - Response fields hold stable while rsp_valid & !rsp_ready.
- Decode errors (err=1, rdata=0, no side effect):
  - offset outside the map;
  - addr[1:0]!=0;
  - a CFG write while busy_i=1.
- Write masking:
  - Masked byte lanes are unchanged.
  - wmask=0 is a legal no-op write, err=0.
  - For CTRL/STATUS/IRQ_EN only lane 0 matters.
- Start/abort pulses:
  - A CTRL write with start=1 and lane 0 enabled pulses start_o in the cycle after acceptance. If busy_i=1 the pulse is suppressed, err=0.
  - abort is pulsed regardless of busy. Start and abort both set: abort wins, no start.
- done:
  - Set by done_i; cleared by writing STATUS bit0=1.
  - done_i and the clear in the same cycle: set wins.
- irq_o: registered done & irq_en (1 cycle after either changes).
- Reads of STATUS return busy_i sampled at acceptance.
- Reset mid-transaction drops any pending response; no response is ever issued for it.

Decomposition:
- Shared package acc_csr_pkg:
  - offset constants and width localparams;
  - CTRL/STATUS bit indices;
  - a function computing the offset of CTRL/STATUS/IRQ_EN from NUM_CFG.
- Sub-module icb_rsp_slot: the one-entry response register (valid/rdata/err, ready = !valid|rsp_ready).
- Decode and registers live in the top.

Test Plan:
- Write CFG[2] wdata=32'hAABBCCDD wmask=4'b0101 over prior 32'h11223344 -> cfg_o[95:64]=32'h11BB33DD; a read returns it, err=0.
- Hold rsp_ready=0 after one command -> cmd_ready=0 with rsp held stable 3 cycles. Then rsp_ready=1 with a new command every cycle -> 4 responses in 4 cycles.
- Read offset 4*NUM_CFG+12 and addr 0x5 -> err=1, rdata=0, no register changed.
- CTRL write 32'h1 with busy_i=0 -> start_o high exactly 1 cycle; repeat with busy_i=1 -> no pulse, err=0. Write 32'h3 -> abort_o pulse only.
- Pulse done_i, IRQ_EN=1 -> irq_o=1; STATUS write 32'h1 simultaneous with done_i -> done stays 1; a later W1C -> done=0, irq_o=0 next cycle.
- CFG write while busy_i=1 -> err=1, value kept. Assert rst_n=0 with rsp pending -> rsp_valid=0, cfg_o=CFG_RST.
